// File: rtl/jtframe_sharpen.sv
// Horizontal 3-tap unsharp-mask filter for RGB video: boosts each centre pixel
// against its left/right neighbours with runtime strength k, one MAC tap per clock.
module jtframe_sharpen #(
  parameter int unsigned WIN  = 4,
  parameter int unsigned WOUT = 5,
  parameter int unsigned WK   = 3,
  parameter int unsigned AW   = WOUT + WK + 3
) (
  input  logic            rst_n,
  input  logic            clk,
  input  logic            spl_in,
  input  logic [WIN-1:0]  r_in,
  input  logic [WIN-1:0]  g_in,
  input  logic [WIN-1:0]  b_in,
  input  logic            HS_in,
  input  logic            VS_in,
  input  logic            enable,
  input  logic [WK-1:0]   k,
  output logic            spl_out,
  output logic [WOUT-1:0] r_out,
  output logic [WOUT-1:0] g_out,
  output logic [WOUT-1:0] b_out,
  output logic            HS_out,
  output logic            VS_out
);

  localparam int unsigned NCH  = 3;
  localparam int unsigned OMAX = (1 << WOUT) - 1;
  localparam logic signed [AW-1:0] GAIN0 = AW'(8);
  localparam logic signed [AW-1:0] YMAX  = AW'(OMAX);

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_S0   = 5'b00010,
    ST_S1   = 5'b00100,
    ST_S2   = 5'b01000,
    ST_S3   = 5'b10000
  } state_t;

  // Replicate the MSBs into the new LSBs so full scale maps to full scale
  function automatic logic [WOUT-1:0] ext(input logic [WIN-1:0] x);
    ext = (WOUT'(x) << (WOUT - WIN)) | WOUT'(x >> (2 * WIN - WOUT));
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIN-1:0]        r_a    [NCH];
  logic [WIN-1:0]        r_c    [NCH];
  logic [WIN-1:0]        r_b    [NCH];
  logic signed [AW-1:0]  r_acc  [NCH];
  logic [WOUT-1:0]       r_dout [NCH];
  logic [WK-1:0]         r_k;
  logic                  r_en;
  logic [1:0]            r_hs;
  logic [1:0]            r_vs;
  logic                  r_spl;
  logic                  r_hs_out;
  logic                  r_vs_out;

  logic [WIN-1:0]        w_din  [NCH];
  logic signed [AW-1:0]  w_ea   [NCH];
  logic signed [AW-1:0]  w_ec   [NCH];
  logic signed [AW-1:0]  w_eb   [NCH];
  logic signed [AW-1:0]  w_y    [NCH];
  logic [WOUT-1:0]       w_clip [NCH];
  logic signed [AW-1:0]  w_kk;
  logic signed [AW-1:0]  w_gain;

  assign w_din[0] = r_in;
  assign w_din[1] = g_in;
  assign w_din[2] = b_in;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A new sample restarts the sequence from any step, dropping the one in flight
  always_comb begin
    w_state_nxt = r_state;
    if (spl_in) begin
      w_state_nxt = ST_S0;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_S0:   w_state_nxt = ST_S1;
        ST_S1:   w_state_nxt = ST_S2;
        ST_S2:   w_state_nxt = ST_S3;
        ST_S3:   w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Tap operands, floored result and output clamp
  always_comb begin
    w_kk   = AW'(r_k);
    w_gain = GAIN0 + (w_kk <<< 1);
    for (int i = 0; i < NCH; i++) begin
      w_ea[i]   = AW'(ext(r_a[i]));
      w_ec[i]   = AW'(ext(r_c[i]));
      w_eb[i]   = AW'(ext(r_b[i]));
      w_y[i]    = r_acc[i] >>> 3;
      w_clip[i] = WOUT'(w_y[i]);
      if (w_y[i][AW-1])     w_clip[i] = '0;
      else if (w_y[i] > YMAX) w_clip[i] = WOUT'(OMAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_a[i]    <= '0;
        r_c[i]    <= '0;
        r_b[i]    <= '0;
        r_acc[i]  <= '0;
        r_dout[i] <= '0;
      end
      r_k      <= '0;
      r_en     <= 1'b0;
      r_hs     <= '0;
      r_vs     <= '0;
      r_spl    <= 1'b0;
      r_hs_out <= 1'b0;
      r_vs_out <= 1'b0;
    end else begin
      r_spl <= 1'b0;
      if (spl_in) begin
        for (int i = 0; i < NCH; i++) begin
          r_a[i] <= r_c[i];
          r_c[i] <= r_b[i];
          r_b[i] <= w_din[i];
        end
        r_k  <= k;
        r_en <= enable;
        r_hs <= {r_hs[0], HS_in};
        r_vs <= {r_vs[0], VS_in};
      end else begin
        case (r_state)
          ST_S0: for (int i = 0; i < NCH; i++) r_acc[i] <= w_gain * w_ec[i];
          ST_S1: for (int i = 0; i < NCH; i++) r_acc[i] <= r_acc[i] - w_kk * w_ea[i];
          ST_S2: for (int i = 0; i < NCH; i++) r_acc[i] <= r_acc[i] - w_kk * w_eb[i];
          ST_S3: begin
            for (int i = 0; i < NCH; i++)
              r_dout[i] <= r_en ? w_clip[i] : ext(r_c[i]);
            r_spl    <= 1'b1;
            r_hs_out <= r_hs[1];
            r_vs_out <= r_vs[1];
          end
          default: ;
        endcase
      end
    end
  end

  assign spl_out = r_spl;
  assign r_out   = r_dout[0];
  assign g_out   = r_dout[1];
  assign b_out   = r_dout[2];
  assign HS_out  = r_hs_out;
  assign VS_out  = r_vs_out;

endmodule

// File: tb/tb_jtframe_sharpen.sv
// Scoreboard bench for jtframe_sharpen: a floor-division reference model predicts
// every output pixel and its arrival cycle; a monitor checks each spl_out.
module tb_jtframe_sharpen;

  localparam int unsigned WIN  = 4;
  localparam int unsigned WOUT = 5;
  localparam int unsigned WK   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            spl_in;
  logic [WIN-1:0]  r_in, g_in, b_in;
  logic            HS_in, VS_in, enable;
  logic [WK-1:0]   k;
  logic            spl_out;
  logic [WOUT-1:0] r_out, g_out, b_out;
  logic            HS_out, VS_out;

  jtframe_sharpen #(.WIN(WIN), .WOUT(WOUT), .WK(WK)) dut (
    .rst_n(rst_n), .clk(clk), .spl_in(spl_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .HS_in(HS_in), .VS_in(VS_in), .enable(enable), .k(k),
    .spl_out(spl_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .HS_out(HS_out), .VS_out(VS_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r; int g; int b;
    bit hs; bit vs;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // model state: left, centre, newest sample per channel and the sync history
  int ma[3], mc[3], mb[3];
  bit hb, hc, vb, vc;

  always @(posedge clk) cyc++;

  function automatic int ext(input int x);
    return (x << (WOUT - WIN)) | (x >> (2 * WIN - WOUT));
  endfunction

  function automatic int ref_px(input int a, input int c, input int b, input int kk, input bit en);
    int y;
    if (!en) return ext(c);
    y = (8 + 2 * kk) * ext(c) - kk * (ext(a) + ext(b));
    y = (y >= 0) ? (y / 8) : -((-y + 7) / 8);
    if (y < 0) y = 0;
    if (y > (1 << WOUT) - 1) y = (1 << WOUT) - 1;
    return y;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin ma[i] = 0; mc[i] = 0; mb[i] = 0; end
    hb = 0; hc = 0; vb = 0; vc = 0;
  endtask

  // Issue one sample; the next sample follows 'gap' clocks later
  task automatic send(input int rr, input int gg, input int bb, input bit hs, input bit vs,
                      input int kk, input bit en, input int gap);
    int   d[3];
    exp_t e;
    d[0] = rr; d[1] = gg; d[2] = bb;
    @(negedge clk);
    spl_in = 1'b1;
    r_in = WIN'(rr); g_in = WIN'(gg); b_in = WIN'(bb);
    HS_in = hs; VS_in = vs; k = WK'(kk); enable = en;
    for (int i = 0; i < 3; i++) begin ma[i] = mc[i]; mc[i] = mb[i]; mb[i] = d[i]; end
    hc = hb; hb = hs; vc = vb; vb = vs;
    if (gap >= 5) begin
      e.r = ref_px(ma[0], mc[0], mb[0], kk, en);
      e.g = ref_px(ma[1], mc[1], mb[1], kk, en);
      e.b = ref_px(ma[2], mc[2], mb[2], kk, en);
      e.hs = hc; e.vs = vc;
      e.cyc = cyc + 5;
      q.push_back(e);
    end
    repeat (gap - 1) begin
      @(negedge clk);
      spl_in = 1'b0;
      r_in = WIN'($urandom); g_in = WIN'($urandom); b_in = WIN'($urandom);
      HS_in = 1'($urandom); VS_in = 1'($urandom);
      k = WK'($urandom); enable = 1'($urandom);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({spl_out, r_out, g_out, b_out, HS_out, VS_out} != '0) begin
      errors++;
      $display("FAIL %s: spl=%0d rgb=%0d,%0d,%0d hs=%0d vs=%0d, required all 0",
               name, spl_out, r_out, g_out, b_out, HS_out, VS_out);
    end
  endtask

  // Monitor: every output strobe must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (spl_out === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_spl_out at cycle %0d rgb=%0d,%0d,%0d", cyc, r_out, g_out, b_out);
      end else begin
        mon_e = q.pop_front();
        if (r_out != WOUT'(mon_e.r) || g_out != WOUT'(mon_e.g) || b_out != WOUT'(mon_e.b) ||
            HS_out != mon_e.hs || VS_out != mon_e.vs || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL pixel: got rgb=%0d,%0d,%0d hs=%0d vs=%0d cyc=%0d, required rgb=%0d,%0d,%0d hs=%0d vs=%0d cyc=%0d",
                   r_out, g_out, b_out, HS_out, VS_out, cyc,
                   mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; spl_in = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    HS_in = 1'b0; VS_in = 1'b0; enable = 1'b1; k = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // flat field and clamp corners, k=2
    repeat (4) send(8, 8, 8, 0, 0, 2, 1, 6);
    send(0, 15, 15, 0, 0, 2, 1, 6);
    send(15, 15, 0, 0, 0, 2, 1, 6);
    send(15, 0, 8, 0, 0, 2, 1, 6);
    send(0, 15, 0, 0, 0, 2, 1, 6);
    send(15, 0, 0, 0, 0, 2, 1, 6);
    send(0, 8, 15, 0, 0, 2, 1, 6);
    send(8, 0, 0, 0, 0, 2, 1, 6);

    // identity: k=0 sharpen, then bypass with k=7
    repeat (8) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 0, 1, 6);
    repeat (8) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 7, 0, 6);

    // period 3 drops outputs until a long gap
    repeat (5) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 3, 1, 3);
    send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 3, 1, 4);
    repeat (3) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 3, 1, 6);

    // single HS pulse and a VS pulse follow their own pixel
    send(4, 5, 6, 0, 0, 1, 1, 6);
    send(7, 8, 9, 1, 0, 1, 1, 6);
    send(1, 2, 3, 0, 1, 1, 1, 6);
    repeat (2) send(9, 9, 9, 0, 0, 1, 1, 6);

    // fully random traffic, including occasional short periods
    repeat (60) begin
      int gap;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 4) : $urandom_range(5, 8);
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom), gap);
    end
    send(3, 3, 3, 0, 0, 4, 1, 6);

    // reset two clocks after the sampling edge suppresses the pending output
    @(negedge clk);
    spl_in = 1'b1; r_in = 4'd12; g_in = 4'd7; b_in = 4'd2; HS_in = 1'b1; VS_in = 1'b1; k = 3'd3; enable = 1'b1;
    @(negedge clk);
    spl_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    check_zero("mid_reset_outputs");
    repeat (4) @(negedge clk);
    check_zero("mid_reset_hold");
    rst_n = 1'b1;

    // window restarts from zeros after reset
    send(15, 15, 15, 0, 0, 5, 1, 6);
    send(10, 4, 15, 1, 0, 5, 1, 6);
    repeat (4) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 1, 6, 1, 6);

    repeat (12) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: %0d pixels still pending, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
